demux_stream_n: RTL
===================

Name: demux_stream_n

Overview:
- Parametrised successor to the 2-to-4 data decoder used in the MIPS pipeline.
- Routes one input word stream to one of NUM_OUT output channels, or to all channels in broadcast mode.
- Each output channel has a one-entry holding register and a valid/ready handshake, so a stalled consumer back-pressures the producer instead of losing data.
- Sits between a pipeline stage and multiple downstream consumers: writeback ports, debug taps, forwarding sinks.

Parameters:
- WIDTH, 32, data word width in bits (1..64).
- NUM_OUT, 4, number of output channels (2..16; need not be a power of two).
- ZERO_IDLE, 1, when 1 an invalid channel drives out_data as all zeros; when 0 it holds its last data.
- SEL_W, derived localparam = $clog2(NUM_OUT), select width; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  input word accepted this cycle when in_valid is also high.
- in_data  in  WIDTH  input word.
- in_sel  in  SEL_W  destination channel index.
- in_bcast  in  1  when 1, deliver to all channels and ignore in_sel.
- out_valid  out  NUM_OUT  per-channel word present.
- out_ready  in  NUM_OUT  per-channel consumer ready.
- out_data  out  NUM_OUT*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- sel_err  out  1  one-cycle pulse: a word was dropped because of an out-of-range in_sel.
- busy  out  1  OR of out_valid.

Behaviour:
- Reset (rst_n low at a clk edge):
  - all out_valid = 0, all slot data = 0, sel_err = 0.
  - in_ready is still computed combinationally, but no transfer is accepted while rst_n is low.
  - Reset mid-transfer discards held words; no partial delivery.
- Per-channel free condition: free[i] = !out_valid[i] || out_ready[i]. A channel being drained in the same cycle counts as free.
- in_ready (combinational; path from out_ready and in_sel is intentional):
  - in_bcast = 1: AND of all free[i].
  - in_bcast = 0 and in_sel < NUM_OUT: free[in_sel].
  - in_bcast = 0 and in_sel >= NUM_OUT: 1.
- Accept = in_valid && in_ready && rst_n.
  - Accepted word is registered and appears on out_valid/out_data the next cycle; latency 1.
  - No combinational path from in_data to out_data.
- Targeted accept: only channel in_sel loads; all other channels are unaffected.
- Broadcast accept: all channels load the same word in the same cycle; all-or-nothing, never a partial broadcast.
- Out-of-range select (in_bcast = 0, in_sel >= NUM_OUT):
  - Word is consumed and dropped.
  - sel_err = 1 for exactly the following cycle.
  - No out_valid changes.
- Per-channel slot update each clk:
  - load: out_valid = 1, data = in_data.
  - else drain (out_valid && out_ready): out_valid = 0.
  - else hold.
  - Load and drain in the same cycle: the new word replaces the old and out_valid stays 1, giving full throughput of one word per cycle per channel.
- Stability: while out_valid[i] = 1 and out_ready[i] = 0, out_data[i] stays constant.
- ZERO_IDLE = 1: out_data[i] = 0 whenever out_valid[i] = 0. This matches the zero-on-unselected output convention of the existing decoder.
- No ordering guarantee across channels; within a channel, words are delivered in acceptance order.

Decomposition:
- No typedefs are needed.
- WIDTH/NUM_OUT defaults go in the shared pipeline constants include alongside the other datapath widths.
- One sub-module, demux_slot (parameter WIDTH, ZERO_IDLE):
  - ports clk, rst_n, load, d, ready, valid, q, free.
  - Instantiated NUM_OUT times by a generate loop.
  - The top module holds only the in_ready/select/broadcast/sel_err logic.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with in_valid = 1 -> out_valid = 0000, out_data all 0, sel_err = 0, no load after release until in_valid is re-sampled.
- Targeted streaming: NUM_OUT = 4, WIDTH = 32, out_ready = 1111, send 0xA0..0xA7 with in_sel = i%4 -> each word on its channel one cycle later; 8 words in 8 cycles; ZERO_IDLE channels read 0 when not valid.
- Back-pressure: out_ready[2] = 0, send 0x11 then 0x22 to channel 2 -> 0x11 held stable, in_ready = 0 on the second word. Raise out_ready[2] -> 0x22 loads in the same cycle 0x11 drains, and out_valid[2] never drops.
- Broadcast all-or-nothing: out_valid[1] = 1 with out_ready[1] = 0, in_bcast = 1, data 0x5A -> in_ready = 0 and no channel loads. Release out_ready[1] -> all four channels show 0x5A the next cycle.
- Out-of-range: NUM_OUT = 3, in_sel = 3, data 0xDEAD -> in_ready = 1, sel_err pulses exactly one cycle, out_valid unchanged.
- Mid-operation reset: all channels valid and stalled, rst_n = 0 for one edge -> all out_valid = 0 the next cycle; subsequent transfer to channel 0 delivers correctly with latency 1.

Source files
------------

// File: rtl/demux_stream_n_pkg.sv
// Shared datapath constants and helpers for the stream demultiplexer.
package demux_stream_n_pkg;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_NUM_OUT = 4;

  // True when a select value addresses an existing channel.
  function automatic logic sel_in_range(input int sel, input int num_out);
    return (sel >= 0) && (sel < num_out);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register with valid/ready handshake for a single output channel.
module demux_slot #(
  parameter int WIDTH     = 32,
  parameter int ZERO_IDLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] q,
  output logic             free
);

  logic [WIDTH-1:0] data;

  // Load has priority over drain, so a word arriving while the old one leaves keeps the slot full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  assign free = !valid || ready;
  assign q    = ((ZERO_IDLE != 0) && !valid) ? '0 : data;

endmodule

// File: rtl/demux_stream_n.sv
// Routes one valid/ready word stream to one of NUM_OUT channels or broadcasts it to all.
module demux_stream_n
  import demux_stream_n_pkg::*;
#(
  parameter int  WIDTH     = DEFAULT_WIDTH,
  parameter int  NUM_OUT   = DEFAULT_NUM_OUT,
  parameter int  ZERO_IDLE = 1,
  localparam int SEL_W     = $clog2(NUM_OUT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic                     sel_err,
  output logic                     busy
);

  logic [NUM_OUT-1:0] free;
  logic [NUM_OUT-1:0] sel_hit;
  logic [NUM_OUT-1:0] load;
  logic               sel_valid;
  logic               accept;

  // Decode the target channel and decide whether the addressed channel(s) can take a word now.
  always_comb begin
    sel_hit   = '0;
    sel_valid = sel_in_range(int'(in_sel), NUM_OUT);
    for (int i = 0; i < NUM_OUT; i++) begin
      sel_hit[i] = (int'(in_sel) == i);
    end
    if (in_bcast) begin
      in_ready = &free;
    end else if (sel_valid) begin
      in_ready = |(sel_hit & free);
    end else begin
      in_ready = 1'b1;
    end
  end

  assign accept = in_valid && in_ready && rst_n;
  assign load   = accept ? (in_bcast ? {NUM_OUT{1'b1}} : sel_hit) : '0;
  assign busy   = |out_valid;

  // Flag, one cycle late, a word that was swallowed because it addressed a missing channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= accept && !in_bcast && !sel_valid;
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_slot
    demux_slot #(
      .WIDTH     (WIDTH),
      .ZERO_IDLE (ZERO_IDLE)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[g]),
      .d     (in_data),
      .ready (out_ready[g]),
      .valid (out_valid[g]),
      .q     (out_data[g*WIDTH +: WIDTH]),
      .free  (free[g])
    );
  end

endmodule
